heap_pq: RTL

Parametrised binary-heap priority queue, the next generation of the team's single-key heap controller. It stores up to DEPTH keys of DATA_W bits in an internal register array and supports push, pop and replace (pop-then-push in one operation). Max-heap or min-heap ordering is set by a parameter. Each operation is a start/done transaction, with full, empty and error status for the upstream scheduler.

---
 rtl/heap_pq.sv | 320 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/heap_pq.sv
// -----------------------------------------------------------------------------
// heap_pq -- binary-heap priority queue with start/done transactions.
//
// Holds up to DEPTH unsigned keys of DATA_W bits in a register array laid out
// as an implicit binary heap (children of i at 2i+1 and 2i+2). The root holds
// the "best" key: largest for a max-heap (MIN_HEAP=0), smallest for a
// min-heap (MIN_HEAP=1). Equal keys never swap.
//
// Operations (instruction, sampled with start while idle):
//   00 no-op    -> completes next cycle, err=0
//   01 push     -> append key at slot n, then sift up
//   10 pop      -> move last key to the root, shrink, then sift down
//   11 replace  -> overwrite the root with key, then sift down
// Push on a full heap, or pop/replace on an empty heap, complete next cycle
// with err=1 and leave the heap untouched.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        request strobe, honoured only in IDLE
//   instruction  operation code (see above)
//   key          key operand for push/replace
//   busy         high while a sift is in progress
//   done         one-cycle completion pulse
//   err          result of the last operation, valid with done
//   n            number of stored keys, 0..DEPTH
//   top          root key when n>0, else 0 (stable while busy=0)
//   empty        n==0
//   full         n==DEPTH
// -----------------------------------------------------------------------------
module heap_pq #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit MIN_HEAP = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        instruction,
  input  logic [DATA_W-1:0] key,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   n,
  output logic [DATA_W-1:0] top,
  output logic              empty,
  output logic              full
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SIFT_UP,
    S_SIFT_DOWN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  localparam logic [ADDR_W:0]   DEPTH_N = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W+1:0] CH_ONE  = {{(ADDR_W+1){1'b0}}, 1'b1};
  localparam logic [ADDR_W+1:0] CH_TWO  = {{ADDR_W{1'b0}}, 2'b10};

  // Strict heap ordering: true when a must sit above b.
  function automatic logic better(input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b);
    if (MIN_HEAP) return a < b;
    else          return a > b;
  endfunction

  state_e            state;
  logic [ADDR_W:0]   idx;          // node currently being sifted
  logic [DATA_W-1:0] mem [DEPTH];

  op_e op;
  assign op = op_e'(instruction);

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign empty = (n == '0);
  assign full  = (n == DEPTH_N);
  assign top   = empty ? '0 : mem[0];

  // ---------------------------------------------------------------------------
  // Index arithmetic. Child indices carry one extra bit beyond n so that
  // 2i+2 for the deepest internal node cannot wrap back into the valid range.
  // ---------------------------------------------------------------------------
  logic [ADDR_W:0]   parent_idx;
  logic [ADDR_W:0]   last_idx;
  logic [ADDR_W+1:0] left_idx;
  logic [ADDR_W+1:0] right_idx;
  logic [ADDR_W+1:0] n_ext;

  assign parent_idx = (idx - IDX_ONE) >> 1;
  assign last_idx   = n - IDX_ONE;
  assign left_idx   = {idx, 1'b0} + CH_ONE;
  assign right_idx  = {idx, 1'b0} + CH_TWO;
  assign n_ext      = {1'b0, n};

  logic [DATA_W-1:0] cur_val;
  logic [DATA_W-1:0] par_val;
  logic [DATA_W-1:0] left_val;
  logic [DATA_W-1:0] right_val;
  logic [DATA_W-1:0] last_val;

  // Out-of-range reads are harmless: the values are only used once the
  // corresponding index has been qualified against n.
  assign cur_val   = mem[idx[ADDR_W-1:0]];
  assign par_val   = mem[parent_idx[ADDR_W-1:0]];
  assign left_val  = mem[left_idx[ADDR_W-1:0]];
  assign right_val = mem[right_idx[ADDR_W-1:0]];
  assign last_val  = mem[last_idx[ADDR_W-1:0]];

  // ---------------------------------------------------------------------------
  // Sift decisions: one compare (up) or a three-way pick (down) per cycle.
  // ---------------------------------------------------------------------------
  logic              up_swap;
  logic              down_swap;
  logic [ADDR_W:0]   best_idx;
  logic [DATA_W-1:0] best_val;

  assign up_swap = (idx != '0) && better(cur_val, par_val);

  // NOTE: every variable assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    best_idx = idx;
    best_val = cur_val;
    if ((left_idx < n_ext) && better(left_val, best_val)) begin
      best_idx = left_idx[ADDR_W:0];
      best_val = left_val;
    end
    if ((right_idx < n_ext) && better(right_val, best_val)) begin
      best_idx = right_idx[ADDR_W:0];
      best_val = right_val;
    end
  end

  assign down_swap = (best_idx != idx);

  // ---------------------------------------------------------------------------
  // Array write ports. Port A covers the single write of push/pop/replace and
  // the "move parent/child into idx" half of a swap; port B writes the old
  // value of idx into the other node. The two addresses never coincide.
  // ---------------------------------------------------------------------------
  logic              wa_en;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  always_comb begin
    wa_en   = 1'b0;
    wa_addr = '0;
    wa_data = '0;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_PUSH: if (!full) begin
              wa_en   = 1'b1;
              wa_addr = n[ADDR_W-1:0];
              wa_data = key;
            end
            OP_POP: if (!empty) begin
              wa_en   = 1'b1;
              wa_addr = '0;
              wa_data = last_val;
            end
            OP_REPL: if (!empty) begin
              wa_en   = 1'b1;
              wa_addr = '0;
              wa_data = key;
            end
            default: ;
          endcase
        end
      end
      S_SIFT_UP: begin
        if (up_swap) begin
          wa_en   = 1'b1;
          wa_addr = idx[ADDR_W-1:0];
          wa_data = par_val;
          wb_en   = 1'b1;
          wb_addr = parent_idx[ADDR_W-1:0];
          wb_data = cur_val;
        end
      end
      S_SIFT_DOWN: begin
        if (down_swap) begin
          wa_en   = 1'b1;
          wa_addr = idx[ADDR_W-1:0];
          wa_data = best_val;
          wb_en   = 1'b1;
          wb_addr = best_idx[ADDR_W-1:0];
          wb_data = cur_val;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the key array is deliberately left out of reset; n=0 makes every
  // slot a don't-care, and a reset-free array maps onto plain storage.
  // NOTE: non-blocking assignments let both halves of a swap read the values
  // from before the edge, so the exchange needs no temporary.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wa_en) mem[wa_addr] <= wa_data;
      if (wb_en) mem[wb_addr] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered busy/done/err.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      n     <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err <= 1'b0;
            case (op)
              OP_PUSH: begin
                if (!full) begin
                  n     <= n + IDX_ONE;
                  idx   <= n;
                  busy  <= 1'b1;
                  state <= S_SIFT_UP;
                end else begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= S_DONE;
                end
              end
              OP_POP: begin
                if (!empty) begin
                  n   <= last_idx;
                  idx <= '0;
                  // Popping the only key leaves nothing to sift.
                  if (n == IDX_ONE) begin
                    done  <= 1'b1;
                    state <= S_DONE;
                  end else begin
                    busy  <= 1'b1;
                    state <= S_SIFT_DOWN;
                  end
                end else begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= S_DONE;
                end
              end
              OP_REPL: begin
                if (!empty) begin
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= S_SIFT_DOWN;
                end else begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= S_DONE;
                end
              end
              default: begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            endcase
          end
        end

        S_SIFT_UP: begin
          if (up_swap) begin
            idx <= parent_idx;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_SIFT_DOWN: begin
          if (down_swap) begin
            idx <= best_idx;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        default: begin
          // S_DONE: the pulse lasts one cycle; err holds until the next start.
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
